// File: rtl/simon_pkg.sv
// Shared constants, register map and FSM state types for the SIMON config block.
// The IRQ_EN register is built only when SIMON_CFG_IRQ_EN is defined.
package simon_pkg;

  localparam int CFG_ADDR_WIDTH = 8;
  localparam int CFG_DATA_WIDTH = 32;
  localparam int CFG_STRB_WIDTH = CFG_DATA_WIDTH / 8;
  localparam int CFG_PROT_WIDTH = 3;
  localparam int CFG_RESP_WIDTH = 2;

  localparam int OFF_CTRL   = 'h00;
  localparam int OFF_STATUS = 'h04;
  localparam int OFF_KEY0   = 'h08;
  localparam int OFF_KEY1   = 'h0C;
  localparam int OFF_KEY2   = 'h10;
  localparam int OFF_KEY3   = 'h14;
  localparam int OFF_IRQ_EN = 'h18;

  localparam logic [2:0] IDX_CTRL   = 3'(OFF_CTRL >> 2);
  localparam logic [2:0] IDX_STATUS = 3'(OFF_STATUS >> 2);
  localparam logic [2:0] IDX_KEY0   = 3'(OFF_KEY0 >> 2);
  localparam logic [2:0] IDX_KEY1   = 3'(OFF_KEY1 >> 2);
  localparam logic [2:0] IDX_KEY2   = 3'(OFF_KEY2 >> 2);
  localparam logic [2:0] IDX_KEY3   = 3'(OFF_KEY3 >> 2);
  localparam logic [2:0] IDX_IRQ_EN = 3'(OFF_IRQ_EN >> 2);

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  localparam logic [CFG_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [CFG_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  function automatic logic [CFG_DATA_WIDTH-1:0] strb_merge(
    input logic [CFG_DATA_WIDTH-1:0] old_v,
    input logic [CFG_DATA_WIDTH-1:0] new_v,
    input logic [CFG_STRB_WIDTH-1:0] strb
  );
    logic [CFG_DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < CFG_STRB_WIDTH; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/simon_cfg_regfile.sv
// Register storage for the SIMON config block: key, mode, start pulse, DONE, IRQ.
// IRQ_EN and irq_o exist only when SIMON_CFG_IRQ_EN is defined.
module simon_cfg_regfile
  import simon_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [2:0]                wr_idx_i,
  input  logic [CFG_DATA_WIDTH-1:0] wr_data_i,
  input  logic [CFG_STRB_WIDTH-1:0] wr_strb_i,
  input  logic [2:0]                rd_idx_i,
  input  logic                      busy_i,
  input  logic                      done_i,
  output logic [CFG_DATA_WIDTH-1:0] rd_data_o,
  output logic [127:0]              key_o,
  output logic                      mode_o,
  output logic                      start_o,
  output logic                      irq_o
);

  logic [3:0][31:0] key_q;
  logic mode_q, start_q, done_q;
  logic done_clr, irq_en_rd;

  assign done_clr = wr_en_i && (wr_idx_i == IDX_STATUS)
                 && wr_strb_i[0] && wr_data_i[STAT_DONE_BIT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q   <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      // a completion in the same cycle as the clear wins
      done_q  <= done_i | (done_q & ~done_clr);
      if (wr_en_i) begin
        case (wr_idx_i)
          IDX_CTRL: if (wr_strb_i[0]) begin
            mode_q  <= wr_data_i[CTRL_MODE_BIT];
            start_q <= wr_data_i[CTRL_START_BIT] & ~busy_i;
          end
          IDX_KEY0: key_q[0] <= strb_merge(key_q[0], wr_data_i, wr_strb_i);
          IDX_KEY1: key_q[1] <= strb_merge(key_q[1], wr_data_i, wr_strb_i);
          IDX_KEY2: key_q[2] <= strb_merge(key_q[2], wr_data_i, wr_strb_i);
          IDX_KEY3: key_q[3] <= strb_merge(key_q[3], wr_data_i, wr_strb_i);
          default: ;
        endcase
      end
    end
  end

`ifdef SIMON_CFG_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en_i && wr_idx_i == IDX_IRQ_EN && wr_strb_i[0])
        irq_en_q <= wr_data_i[0];
      irq_q <= done_q & irq_en_q;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq_o     = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

  always_comb begin
    rd_data_o = '0;
    case (rd_idx_i)
      IDX_CTRL:   rd_data_o[CTRL_MODE_BIT] = mode_q;
      IDX_STATUS: begin
        rd_data_o[STAT_BUSY_BIT] = busy_i;
        rd_data_o[STAT_DONE_BIT] = done_q;
      end
      IDX_KEY0:   rd_data_o = key_q[0];
      IDX_KEY1:   rd_data_o = key_q[1];
      IDX_KEY2:   rd_data_o = key_q[2];
      IDX_KEY3:   rd_data_o = key_q[3];
      IDX_IRQ_EN: rd_data_o[0] = irq_en_rd;
      default:    rd_data_o = '0;
    endcase
  end

  assign key_o   = key_q;
  assign mode_o  = mode_q;
  assign start_o = start_q;

endmodule

// File: rtl/simon_cfg_regs.sv
// AXI4-Lite responder for the SIMON cipher core configuration registers.
// Optional interrupt enable register: define SIMON_CFG_IRQ_EN.
module simon_cfg_regs
  import simon_pkg::*;
#(
  parameter int ADDR_W = CFG_ADDR_WIDTH,
  parameter int DATA_W = CFG_DATA_WIDTH
) (
  input  logic                      clk_simon_cfg,
  input  logic                      rst_simon_cfg,
  input  logic [ADDR_W-1:0]         simon_cfg_awaddr,
  input  logic [CFG_PROT_WIDTH-1:0] simon_cfg_awprot,
  input  logic                      simon_cfg_awvalid,
  output logic                      simon_cfg_awready,
  input  logic [DATA_W-1:0]         simon_cfg_wdata,
  input  logic [DATA_W/8-1:0]       simon_cfg_wstrb,
  input  logic                      simon_cfg_wvalid,
  output logic                      simon_cfg_wready,
  output logic                      simon_cfg_bvalid,
  output logic [CFG_RESP_WIDTH-1:0] simon_cfg_bresp,
  input  logic                      simon_cfg_bready,
  input  logic [ADDR_W-1:0]         simon_cfg_araddr,
  input  logic [CFG_PROT_WIDTH-1:0] simon_cfg_arprot,
  input  logic                      simon_cfg_arvalid,
  output logic                      simon_cfg_arready,
  output logic                      simon_cfg_rvalid,
  output logic [CFG_RESP_WIDTH-1:0] simon_cfg_rresp,
  output logic [DATA_W-1:0]         simon_cfg_rdata,
  input  logic                      simon_cfg_rready,
  output logic [127:0]              key_o,
  output logic                      mode_o,
  output logic                      start_o,
  input  logic                      busy_i,
  input  logic                      done_i,
  output logic                      irq_o
);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= ADDR_W'(OFF_IRQ_EN));
  endfunction

  wr_state_e wr_q;
  rd_state_e rd_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [CFG_RESP_WIDTH-1:0] bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q, w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic [ADDR_W-1:0] aw_addr_q;

  logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rf_rdata;
  logic [DATA_W/8-1:0] wr_strb;
  logic unused_prot;

  assign unused_prot = ^{simon_cfg_awprot, simon_cfg_arprot};

  assign aw_hs = simon_cfg_awvalid & awready_q;
  assign w_hs  = simon_cfg_wvalid & wready_q;
  assign ar_hs = simon_cfg_arvalid & arready_q;

  assign wr_addr = (wr_q == WR_WAIT_W)  ? aw_addr_q : simon_cfg_awaddr;
  assign wr_data = (wr_q == WR_WAIT_AW) ? w_data_q  : simon_cfg_wdata;
  assign wr_strb = (wr_q == WR_WAIT_AW) ? w_strb_q  : simon_cfg_wstrb;

  assign commit = (wr_q == WR_IDLE    && aw_hs && w_hs)
               || (wr_q == WR_WAIT_W  && w_hs)
               || (wr_q == WR_WAIT_AW && aw_hs);

  assign wr_ok = addr_ok(wr_addr);
  assign rd_ok = addr_ok(simon_cfg_araddr);

  always_ff @(posedge clk_simon_cfg or negedge rst_simon_cfg) begin
    if (!rst_simon_cfg) begin
      wr_q      <= WR_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      wr_q      <= WR_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wr_q)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= simon_cfg_awaddr;
            awready_q <= 1'b0;
            wr_q      <= WR_WAIT_W;
          end else if (w_hs) begin
            w_data_q <= simon_cfg_wdata;
            w_strb_q <= simon_cfg_wstrb;
            wready_q <= 1'b0;
            wr_q     <= WR_WAIT_AW;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        WR_RESP: if (simon_cfg_bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          wr_q      <= WR_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_simon_cfg or negedge rst_simon_cfg) begin
    if (!rst_simon_cfg) begin
      rd_q      <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (rd_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q   <= rd_ok ? rf_rdata : '0;
            rd_q      <= RD_DATA;
          end
        end
        RD_DATA: if (simon_cfg_rready) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          rd_q      <= RD_IDLE;
        end
        default: rd_q <= RD_IDLE;
      endcase
    end
  end

  simon_cfg_regfile u_regfile (
    .clk_i     (clk_simon_cfg),
    .rst_ni    (rst_simon_cfg),
    .wr_en_i   (commit & wr_ok),
    .wr_idx_i  (wr_addr[4:2]),
    .wr_data_i (wr_data),
    .wr_strb_i (wr_strb),
    .rd_idx_i  (simon_cfg_araddr[4:2]),
    .busy_i    (busy_i),
    .done_i    (done_i),
    .rd_data_o (rf_rdata),
    .key_o     (key_o),
    .mode_o    (mode_o),
    .start_o   (start_o),
    .irq_o     (irq_o)
  );

  assign simon_cfg_awready = awready_q;
  assign simon_cfg_wready  = wready_q;
  assign simon_cfg_bvalid  = bvalid_q;
  assign simon_cfg_bresp   = bresp_q;
  assign simon_cfg_arready = arready_q;
  assign simon_cfg_rvalid  = rvalid_q;
  assign simon_cfg_rresp   = rresp_q;
  assign simon_cfg_rdata   = rdata_q;

endmodule

// File: tb/tb_simon_cfg_regs.sv
// Scoreboard bench for simon_cfg_regs: queued AXI responses checked by a monitor.
// Expected IRQ behaviour follows SIMON_CFG_IRQ_EN.
module tb_simon_cfg_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] key_o;
  logic mode_o, start_o, irq_o;
  logic busy_i = 0, done_i = 0;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [1:0] wq[$];
  logic [33:0] rq[$];

`ifdef SIMON_CFG_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  simon_cfg_regs dut (
    .clk_simon_cfg     (clk),
    .rst_simon_cfg     (rst_n),
    .simon_cfg_awaddr  (awaddr),
    .simon_cfg_awprot  (awprot),
    .simon_cfg_awvalid (awvalid),
    .simon_cfg_awready (awready),
    .simon_cfg_wdata   (wdata),
    .simon_cfg_wstrb   (wstrb),
    .simon_cfg_wvalid  (wvalid),
    .simon_cfg_wready  (wready),
    .simon_cfg_bvalid  (bvalid),
    .simon_cfg_bresp   (bresp),
    .simon_cfg_bready  (bready),
    .simon_cfg_araddr  (araddr),
    .simon_cfg_arprot  (arprot),
    .simon_cfg_arvalid (arvalid),
    .simon_cfg_arready (arready),
    .simon_cfg_rvalid  (rvalid),
    .simon_cfg_rresp   (rresp),
    .simon_cfg_rdata   (rdata),
    .simon_cfg_rready  (rready),
    .key_o             (key_o),
    .mode_o            (mode_o),
    .start_o           (start_o),
    .busy_i            (busy_i),
    .done_i            (done_i),
    .irq_o             (irq_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout got 0 want 1", name);
  endtask

  always @(negedge clk) begin
    if (start_o) start_cnt++;
    if (rst_n && bvalid && bready) begin
      if (wq.size() == 0) tmo("bresp_unexpected");
      else chk("bresp", 32'(bresp), 32'(wq.pop_front()));
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) tmo("rresp_unexpected");
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        chk("rresp", 32'(rresp), 32'(e[33:32]));
        chk("rdata", rdata, e[31:0]);
      end
    end
  end

  task automatic wait_b();
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = bvalid;
    end
    if (!seen) tmo("bvalid_wait");
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    bit ad = 0, wd = 0, ag, wg;
    int n = 0;
    wq.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    while (!(ad && wd) && n < 50) begin
      @(negedge clk);
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(posedge clk); #1;
      if (ag) begin awvalid = 0; ad = 1; end
      if (wg) begin wvalid = 0; wd = 1; end
      n++;
    end
    if (n >= 50) begin
      tmo("aw_w_accept");
      awvalid = 0; wvalid = 0;
    end
    wait_b();
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [1:0] er,
                          input logic [31:0] ed);
    bit got = 0, seen = 0;
    rq.push_back({er, ed});
    araddr = a; arvalid = 1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    if (!got) tmo("ar_accept");
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = rvalid;
    end
    if (!seen) tmo("rvalid_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_key", key_o[31:0] | key_o[127:96], 0);
    chk("rst_mode_irq", {30'b0, mode_o, irq_o}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", {29'b0, awready, wready, arready}, 32'h7);

    axi_write(8'h08, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read(8'h08, 2'b00, 32'hDEADBEEF);
    chk("key0", key_o[31:0], 32'hDEADBEEF);

    // W three cycles ahead of AW
    s0 = start_cnt;
    wq.push_back(2'b00);
    awaddr = 8'h00; wdata = 32'h3; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("aw_wait_bvalid", 32'(bvalid), 0);
    awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("bvalid_after_aw", 32'(bvalid), 1);
    wait_b();
    repeat (2) @(posedge clk);
    #1;
    chk("start_pulses", 32'(start_cnt - s0), 1);
    chk("mode_set", 32'(mode_o), 1);

    axi_write(8'h0C, 32'h11223344, 4'h5, 2'b00);
    axi_read(8'h0C, 2'b00, 32'h00220044);

    axi_read(8'h1C, 2'b10, 32'h0);
    axi_write(8'h02, 32'h0, 4'hF, 2'b10);
    axi_read(8'h00, 2'b00, 32'h2);
    axi_read(8'h08, 2'b00, 32'hDEADBEEF);

    // read and write of KEY2 committing in the same cycle
    fork
      axi_write(8'h10, 32'hCAFEF00D, 4'hF, 2'b00);
      axi_read(8'h10, 2'b00, 32'h0);
    join
    axi_read(8'h10, 2'b00, 32'hCAFEF00D);

    busy_i = 1;
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'hF, 2'b00);
    axi_read(8'h04, 2'b00, 32'h1);
    chk("busy_no_start", 32'(start_cnt - s0), 0);
    busy_i = 0;

    axi_write(8'h18, 32'h1, 4'hF, 2'b00);
    axi_read(8'h18, 2'b00, {31'b0, IRQ_BUILD});
    done_i = 1;
    @(posedge clk); #1;
    done_i = 0;
    axi_read(8'h04, 2'b00, 32'h2);
    chk("irq_on", 32'(irq_o), 32'(IRQ_BUILD));

    wq.push_back(2'b00);
    awaddr = 8'h04; wdata = 32'h2; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; done_i = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done_i = 0;
    wait_b();
    axi_read(8'h04, 2'b00, 32'h2);

    axi_write(8'h04, 32'h2, 4'hF, 2'b00);
    axi_read(8'h04, 2'b00, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_off", 32'(irq_o), 0);

    // reset while a write response is stalled
    bready = 0;
    wq.push_back(2'b00);
    awaddr = 8'h14; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("stall_bvalid", 32'(bvalid), 1);
    chk("key3_written", key_o[127:96], 32'hA5A5A5A5);
    #2 rst_n = 0;
    #1;
    chk("rst_drop_bvalid", 32'(bvalid), 0);
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    bready = 1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("key_after_rst", key_o[127:96] | key_o[31:0], 0);
    chk("no_resp_after_rst", 32'(bvalid), 0);
    chk("wq_empty", 32'(wq.size() + rq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
